// File: rtl/shift_add_mult_core.sv
// ---------------------------------------------------------------------------
// shift_add_mult_core
//
// Sequential unsigned shift-and-add multiplier. One multiplier bit is
// consumed per ADD+SHIFT pair, so a WIDTH-bit operation takes one load edge
// plus 2*WIDTH edges. The 2*WIDTH-bit product is left in AQ = {A,Q}.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high reset
//   start  - operation request; a new operation begins on its rising edge
//   M      - multiplicand (WIDTH bits), held stable by the user while busy
//   Qin    - multiplier (WIDTH bits), captured on the load edge
//   AQ     - {A,Q} register (2*WIDTH bits), holds the product while ready=1
//   ready  - registered, high while the result in AQ is valid
//   add    - registered, high while the sequencer is in the ADD state
//   shift  - registered, high while the sequencer is in the SHIFT state
// ---------------------------------------------------------------------------
module shift_add_mult_core #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   Qin,
  output logic [2*WIDTH-1:0] AQ,
  output logic               ready,
  output logic               add,
  output logic               shift
);

  // The bit counter only has to reach WIDTH-1; keep at least one bit so
  // degenerate widths still elaborate.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic             c_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    count_q;
  logic             startPrev_q;
  logic             ready_q;
  logic             add_q;
  logic             shift_q;

  logic             startRise;
  logic [WIDTH:0]   sum_d;

  // Edge detect on start so that holding it high never retriggers.
  assign startRise = start & ~startPrev_q;

  // Carry-producing adder; the extra top bit becomes the new C.
  assign sum_d = {1'b0, a_q} + {1'b0, M};

  // Sequencer and datapath registers. Moore outputs are registered by
  // setting them together with the state they belong to, so add/shift/ready
  // always reflect the current state and add/shift can never overlap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      c_q         <= 1'b0;
      a_q         <= '0;
      q_q         <= '0;
      count_q     <= '0;
      startPrev_q <= 1'b0;
      ready_q     <= 1'b0;
      add_q       <= 1'b0;
      shift_q     <= 1'b0;
    end else begin
      startPrev_q <= start;
      case (state_q)
        IDLE, DONE: begin
          // Outside a load edge everything holds, so the product and ready
          // stay stable in DONE.
          if (startRise) begin
            a_q     <= '0;
            c_q     <= 1'b0;
            q_q     <= Qin;
            count_q <= '0;
            ready_q <= 1'b0;
            add_q   <= 1'b1;
            shift_q <= 1'b0;
            state_q <= ADD;
          end
        end
        ADD: begin
          // Only add the multiplicand when the current multiplier bit is 1;
          // otherwise A and C keep their values.
          if (q_q[0]) begin
            {c_q, a_q} <= sum_d;
          end
          add_q   <= 1'b0;
          shift_q <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          // Logical right shift of {C,A,Q}: C drops into A's MSB, the
          // consumed multiplier bit falls off Q's LSB, and C is cleared.
          {c_q, a_q, q_q} <= {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
          shift_q <= 1'b0;
          if (count_q == LAST_BIT) begin
            ready_q <= 1'b1;
            state_q <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
            add_q   <= 1'b1;
            state_q <= ADD;
          end
        end
        default: begin
          state_q <= IDLE;
          add_q   <= 1'b0;
          shift_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign AQ    = {a_q, q_q};
  assign ready = ready_q;
  assign add   = add_q;
  assign shift = shift_q;

endmodule

// File: tb/tb_shift_add_mult_core.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_shift_add_mult_core
//
// Self-checking bench for shift_add_mult_core (WIDTH=8). Expected products
// come from plain integer multiplication; the expected timing comes from the
// documented operation length (load edge plus two edges per multiplier bit).
// ---------------------------------------------------------------------------
module tb_shift_add_mult_core;

  localparam int WIDTH      = 8;
  localparam int OP_EDGES   = 2 * WIDTH + 1;
  localparam int EDGE_LIMIT = 64;

  logic               clock;
  logic               reset;
  logic               start;
  logic [WIDTH-1:0]   M;
  logic [WIDTH-1:0]   Qin;
  logic [2*WIDTH-1:0] AQ;
  logic               ready;
  logic               add;
  logic               shift;

  int vectorCount;
  int miscompareCount;

  shift_add_mult_core #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .M     (M),
    .Qin   (Qin),
    .AQ    (AQ),
    .ready (ready),
    .add   (add),
    .shift (shift)
  );

  // 100 MHz free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the design wedges somewhere a bounded wait cannot see.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Run one multiplication. holdStart keeps start high through and past
  // completion; busyPulse issues a second start pulse (with a different Qin)
  // while the operation is still running, which must be ignored.
  task automatic applyStimulus(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                               input bit holdStart, input bit busyPulse);
    int   edges;
    int   adds;
    int   shifts;
    int   both;
    bit   seen;
    logic [2*WIDTH-1:0] expProd;

    expProd = (2*WIDTH)'(int'(m) * int'(q));
    edges   = 0;
    adds    = 0;
    shifts  = 0;
    both    = 0;
    seen    = 1'b0;

    @(negedge clock);
    M     = m;
    Qin   = q;
    start = 1'b1;

    while (!seen && edges < EDGE_LIMIT) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (!holdStart) start = 1'b0;
      if (busyPulse && edges == 4) begin
        start = 1'b1;
        Qin   = ~q;
      end
      if (busyPulse && edges == 5) start = 1'b0;
      if (add)          adds++;
      if (shift)        shifts++;
      if (add && shift) both++;
      if (edges == 1) checkOutput("readyClearedOnLoad", 32'(ready), 32'd0);
      seen = ready;
    end

    checkOutput("latency",    32'(edges),  32'(OP_EDGES));
    checkOutput("addCycles",  32'(adds),   32'(WIDTH));
    checkOutput("shiftCycles", 32'(shifts), 32'(WIDTH));
    checkOutput("addShiftOverlap", 32'(both), 32'd0);
    checkOutput("product",    32'(AQ),     32'(expProd));

    // Result must stay put in DONE (with start still high when held).
    repeat (5) @(negedge clock);
    checkOutput("heldReady",   32'(ready), 32'd1);
    checkOutput("heldProduct", 32'(AQ),    32'(expProd));
    start = 1'b0;
  endtask

  // Abort an operation six edges in with an asynchronous reset; the outputs
  // must clear before the next clock edge arrives.
  task automatic applyMidReset(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
    @(negedge clock);
    M     = m;
    Qin   = q;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midResetAQ",    32'(AQ),    32'd0);
    checkOutput("midResetReady", 32'(ready), 32'd0);
    checkOutput("midResetAdd",   32'(add),   32'd0);
    checkOutput("midResetShift", 32'(shift), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idleAfterReset", 32'({add, shift, ready}), 32'd0);
  endtask

  // Main sequence: reset, directed cases, then randomized operands.
  initial begin
    vectorCount     = 0;
    miscompareCount = 0;
    reset = 1'b1;
    start = 1'b0;
    M     = '0;
    Qin   = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("resetAQ",    32'(AQ),    32'd0);
    checkOutput("resetReady", 32'(ready), 32'd0);
    checkOutput("resetAdd",   32'(add),   32'd0);
    checkOutput("resetShift", 32'(shift), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    applyStimulus(8'h55, 8'h77, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'hAB, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h80, 1'b0, 1'b0);
    applyStimulus(8'h55, 8'h77, 1'b1, 1'b0);
    applyStimulus(8'h3C, 8'hA5, 1'b0, 1'b1);
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);

    applyMidReset(8'h55, 8'h77);
    applyStimulus(8'h55, 8'h77, 1'b0, 1'b0);

    applyStimulus(8'h03, 8'h05, 1'b0, 1'b0);
    applyStimulus(8'h10, 8'h10, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
